// File: rtl/i2c_master_txn_ctrl_if.sv
// Host-side and primitive-side signals of the I2C transaction sequencer.
// The master modport is the sequencer. The slave modport is whatever sits around it:
// the host register interface plus the start, write-byte, read-byte, ack and stop primitives.
interface i2c_master_txn_ctrl_if #(
  parameter int LEN_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_rw;
  logic [6:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;

  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;

  logic [7:0]       rd_data;
  logic             rd_valid;

  logic             done;
  logic             nack_err;
  logic             busy;

  logic             start_go;
  logic             start_finish;

  logic             wb_go;
  logic [7:0]       wb_byte;
  logic             wb_finish;
  logic             wb_ack;

  logic             rb_go;
  logic             rb_finish;
  logic             rb_load;
  logic             rb_data;

  logic             ma_go;
  logic             ma_nack;
  logic             ma_finish;

  logic             stop_go;
  logic             stop_finish;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_len,
    input  wr_data, wr_valid,
    input  start_finish, wb_finish, wb_ack, rb_finish, rb_load, rb_data,
    input  ma_finish, stop_finish,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, nack_err, busy,
    output start_go, wb_go, wb_byte, rb_go, ma_go, ma_nack, stop_go
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_len,
    output wr_data, wr_valid,
    output start_finish, wb_finish, wb_ack, rb_finish, rb_load, rb_data,
    output ma_finish, stop_finish,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, nack_err, busy,
    input  start_go, wb_go, wb_byte, rb_go, ma_go, ma_nack, stop_go
  );
endinterface

// File: rtl/i2c_master_txn_ctrl.sv
// I2C master transaction sequencer: turns one host command into an ordered run of
// START / address byte / data bytes / master ACK-NACK / STOP primitive requests.
// Every output is a flop; a primitive's go rises one cycle after its state is entered
// and drops in the cycle after its finish is sampled.
module i2c_master_txn_ctrl #(
  parameter int LEN_W = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  i2c_master_txn_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_WFETCH,
    S_WRITE,
    S_READ,
    S_MACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] byte_cnt;
  logic [6:0]       addr_q;
  logic             rw_q;
  logic [7:0]       sh;
  logic [7:0]       sh_next;

  logic fin_start;
  logic fin_wb;
  logic fin_rb;
  logic fin_ma;
  logic fin_stop;
  logic cmd_take;
  logic read_entry;

  // A finish only counts while the matching go is up.
  assign fin_start  = bus.start_go & bus.start_finish;
  assign fin_wb     = bus.wb_go    & bus.wb_finish;
  assign fin_rb     = bus.rb_go    & bus.rb_finish;
  assign fin_ma     = bus.ma_go    & bus.ma_finish;
  assign fin_stop   = bus.stop_go  & bus.stop_finish;
  assign cmd_take   = (state == S_IDLE) & bus.cmd_valid;
  assign read_entry = (state != S_READ) & (state_nxt == S_READ);

  // A bit loaded together with rb_finish still lands in the delivered byte.
  assign sh_next = (bus.rb_go & bus.rb_load) ? {sh[6:0], bus.rb_data} : sh;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection from the primitive handshakes
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.cmd_valid) state_nxt = S_START;
      S_START:  if (fin_start) state_nxt = S_ADDR;
      S_ADDR: begin
        if (fin_wb) begin
          if (bus.wb_ack)          state_nxt = S_STOP;
          else if (byte_cnt == '0) state_nxt = S_STOP;
          else if (rw_q)           state_nxt = S_READ;
          else                     state_nxt = S_WFETCH;
        end
      end
      S_WFETCH: if (bus.wr_valid) state_nxt = S_WRITE;
      S_WRITE: begin
        if (fin_wb) begin
          // byte_cnt is decremented on this same edge, so 1 here means "now empty"
          if (bus.wb_ack)                    state_nxt = S_STOP;
          else if (byte_cnt == LEN_W'(1))    state_nxt = S_STOP;
          else                               state_nxt = S_WFETCH;
        end
      end
      S_READ:   if (fin_rb) state_nxt = S_MACK;
      S_MACK: begin
        if (fin_ma) state_nxt = (byte_cnt == '0) ? S_STOP : S_READ;
      end
      S_STOP:   if (fin_stop) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, byte counter and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.start_go  <= 1'b0;
      bus.wb_go     <= 1'b0;
      bus.rb_go     <= 1'b0;
      bus.ma_go     <= 1'b0;
      bus.stop_go   <= 1'b0;
      bus.wr_ready  <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.done      <= 1'b0;
      bus.nack_err  <= 1'b0;
      bus.rd_data   <= 8'h00;
      bus.wb_byte   <= 8'h00;
      bus.ma_nack   <= 1'b0;
      byte_cnt      <= '0;
    end else begin
      bus.cmd_ready <= (state_nxt == S_IDLE);
      bus.busy      <= (state_nxt != S_IDLE);

      bus.start_go  <= (state == S_START) & ~fin_start;
      bus.wb_go     <= ((state == S_ADDR) | (state == S_WRITE)) & ~fin_wb;
      bus.rb_go     <= (state == S_READ) & ~fin_rb;
      bus.ma_go     <= (state == S_MACK) & ~fin_ma;
      bus.stop_go   <= (state == S_STOP) & ~fin_stop;

      bus.wr_ready  <= (state == S_WFETCH) & bus.wr_valid;
      bus.rd_valid  <= fin_rb;
      bus.done      <= fin_stop;

      if (cmd_take) begin
        bus.nack_err <= 1'b0;
        byte_cnt     <= bus.cmd_len;
      end

      if (fin_wb & bus.wb_ack) bus.nack_err <= 1'b1;

      if ((state == S_START) & fin_start) bus.wb_byte <= {addr_q, rw_q};
      if ((state == S_WFETCH) & bus.wr_valid) bus.wb_byte <= bus.wr_data;

      if ((state == S_WRITE) & fin_wb) byte_cnt <= byte_cnt - LEN_W'(1);

      if (fin_rb) begin
        bus.rd_data <= sh_next;
        byte_cnt    <= byte_cnt - LEN_W'(1);
      end

      // Settle ma_nack before ma_go rises and keep it for the whole handshake
      if ((state == S_MACK) & ~bus.ma_go) bus.ma_nack <= (byte_cnt == '0);
    end
  end

  // Latched command fields and the read shifter
  always_ff @(posedge clk) begin
    if (cmd_take) begin
      addr_q <= bus.cmd_addr;
      rw_q   <= bus.cmd_rw;
    end
    if (read_entry) sh <= 8'h00;
    else            sh <= sh_next;
  end

endmodule

// File: tb/tb_i2c_master_txn_ctrl.sv
// Bench for the I2C transaction sequencer: reactive primitive models with random
// latencies, expected primitive sequence built from the command and slave behaviour.
module tb_i2c_master_txn_ctrl;
  localparam int LEN_W    = 4;
  localparam int EV_START = 1 << 8;
  localparam int EV_WB    = 2 << 8;
  localparam int EV_RB    = 3 << 8;
  localparam int EV_MA    = 4 << 8;
  localparam int EV_STOP  = 5 << 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [7:0] wdata [16];
  logic [7:0] rdata [16];
  int         exp_ev[$];
  int         obs_ev[$];
  logic [7:0] exp_rd[$];
  logic [7:0] obs_rd[$];
  int         exp_nwr;
  bit         exp_nack;

  i2c_master_txn_ctrl_if #(.LEN_W(LEN_W)) bus ();

  i2c_master_txn_ctrl #(.LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = 7'h00; bus.cmd_len = '0;
    bus.wr_data = 8'h00; bus.wr_valid = 1'b0;
    bus.start_finish = 1'b0; bus.wb_finish = 1'b0; bus.wb_ack = 1'b0;
    bus.rb_finish = 1'b0; bus.rb_load = 1'b0; bus.rb_data = 1'b0;
    bus.ma_finish = 1'b0; bus.stop_finish = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 32'({bus.start_go, bus.wb_go, bus.rb_go, bus.ma_go, bus.stop_go,
                              bus.wr_ready, bus.rd_valid, bus.done, bus.nack_err, bus.busy,
                              bus.cmd_ready, bus.ma_nack}), 32'h002);
    check({tag, "_rd_data"}, 32'(bus.rd_data), 32'h0);
    check({tag, "_wb_byte"}, 32'(bus.wb_byte), 32'h0);
  endtask

  // Expected transaction from the protocol rules: nack_at is the index of the
  // written byte (0 = address byte) that the slave NACKs, -1 for none.
  function automatic void build_expect(input bit rw, input logic [6:0] addr, input int len,
                                       input int nack_at);
    exp_ev.delete(); exp_rd.delete(); exp_nwr = 0; exp_nack = 1'b0;
    exp_ev.push_back(EV_START);
    exp_ev.push_back(EV_WB + int'({addr, rw}));
    if (nack_at == 0) begin
      exp_nack = 1'b1;
    end else if (rw) begin
      for (int i = 0; i < len; i++) begin
        exp_ev.push_back(EV_RB);
        exp_ev.push_back(EV_MA + ((i == len - 1) ? 1 : 0));
        exp_rd.push_back(rdata[i]);
      end
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_nwr++;
        exp_ev.push_back(EV_WB + int'(wdata[i]));
        if (nack_at == i + 1) begin
          exp_nack = 1'b1;
          break;
        end
      end
    end
    exp_ev.push_back(EV_STOP);
  endfunction

  task automatic run_txn(input bit rw, input logic [6:0] addr, input int len, input int nack_at,
                         input int stall0, input bit abort);
    int   cyc = 0;
    bit   fin = 0;
    bit   onehot_bad = 0;
    bit   stall_bad = 0;
    bit   p_start = 0, p_wb = 0, p_rb = 0, p_ma = 0, p_stop = 0;
    int   wcnt = -1, wb_cnt = 0, wb_done = 0, wr_idx = 0, rb_left = -1, rb_idx = 0;
    int   stall = stall0;
    bit   cur_ack = 0, nack_seen = 0, waiting;
    logic [7:0] rb_word = 8'h00;
    logic nack_obs = 1'b0;

    build_expect(rw, addr, len, nack_at);
    obs_ev.delete(); obs_rd.delete();

    @(negedge clk);
    check("idle_ready", 32'(bus.cmd_ready), 32'h1);
    bus.cmd_valid = 1'b1; bus.cmd_rw = rw; bus.cmd_addr = addr; bus.cmd_len = LEN_W'(len);
    bus.wr_valid = !rw && len > 0 && stall > 0 ? 1'b0 : (!rw && len > 0);
    bus.wr_data = wdata[0];
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("accept_busy_ready_go", 32'({bus.busy, bus.cmd_ready, bus.start_go}), 32'h4);

    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus.start_finish = 1'b0; bus.wb_finish = 1'b0; bus.wb_ack = 1'b0;
      bus.rb_finish = 1'b0; bus.rb_load = 1'b0; bus.rb_data = 1'b0;
      bus.ma_finish = 1'b0; bus.stop_finish = 1'b0;
      // commands outside IDLE must be ignored
      bus.cmd_valid = ($urandom_range(0, 4) == 0);
      bus.cmd_addr = 7'($urandom); bus.cmd_rw = 1'($urandom); bus.cmd_len = LEN_W'($urandom);

      if (cyc == 1) check("start_latency", 32'(bus.start_go), 32'h1);
      if ($countones({bus.start_go, bus.wb_go, bus.rb_go, bus.ma_go, bus.stop_go}) > 1)
        onehot_bad = 1;

      if (bus.start_go && !p_start) begin
        obs_ev.push_back(EV_START); wcnt = $urandom_range(0, 3);
      end
      if (bus.wb_go && !p_wb) begin
        obs_ev.push_back(EV_WB + int'(bus.wb_byte)); wcnt = $urandom_range(0, 3);
        cur_ack = (wb_cnt == nack_at); wb_cnt++;
      end
      if (bus.rb_go && !p_rb) begin
        obs_ev.push_back(EV_RB);
        rb_left = 8; rb_word = rdata[rb_idx]; rb_idx = (rb_idx + 1) % 16;
        if (abort) begin
          #2; rst_n = 1'b0; #1;
          check_reset_outputs("abort");
          break;
        end
      end
      if (bus.ma_go && !p_ma) begin
        obs_ev.push_back(EV_MA + int'(bus.ma_nack)); wcnt = $urandom_range(0, 3);
      end
      if (bus.stop_go && !p_stop) begin
        obs_ev.push_back(EV_STOP); wcnt = $urandom_range(0, 3);
      end
      p_start = bus.start_go; p_wb = bus.wb_go; p_rb = bus.rb_go; p_ma = bus.ma_go;
      p_stop = bus.stop_go;

      if (bus.wr_ready) begin
        wr_idx++; stall = $urandom_range(0, 3);
      end
      if (bus.rd_valid) obs_rd.push_back(bus.rd_data);
      if (bus.done) begin
        nack_obs = bus.nack_err; fin = 1;
      end

      // sequencer is parked waiting for write data
      waiting = !rw && !nack_seen && wr_idx < len && wb_done == wr_idx + 1;
      if (waiting && stall > 0) begin
        stall--;
        if ({bus.start_go, bus.wb_go, bus.rb_go, bus.ma_go, bus.stop_go} != 5'b0) stall_bad = 1;
        bus.start_finish = 1'($urandom); bus.wb_finish = 1'($urandom);
        bus.wb_ack = 1'($urandom); bus.rb_finish = 1'($urandom);
        bus.ma_finish = 1'($urandom); bus.stop_finish = 1'($urandom);
      end

      if (bus.start_go) begin
        if (wcnt == 0) begin bus.start_finish = 1'b1; wcnt = -1; end
        else if (wcnt > 0) wcnt--;
      end
      if (bus.wb_go) begin
        if (wcnt == 0) begin
          bus.wb_finish = 1'b1; bus.wb_ack = cur_ack; wcnt = -1; wb_done++;
          if (cur_ack) nack_seen = 1;
        end else if (wcnt > 0) wcnt--;
      end
      if (bus.rb_go) begin
        if (rb_left > 0) begin
          if ($urandom_range(0, 2) != 0) begin
            bus.rb_load = 1'b1; bus.rb_data = rb_word[rb_left - 1]; rb_left--;
            if (rb_left == 0 && $urandom_range(0, 1) == 1) begin
              bus.rb_finish = 1'b1; rb_left = -1;
            end
          end
        end else if (rb_left == 0) begin
          bus.rb_finish = 1'b1; rb_left = -1;
        end
      end
      if (bus.ma_go) begin
        if (wcnt == 0) begin bus.ma_finish = 1'b1; wcnt = -1; end
        else if (wcnt > 0) wcnt--;
      end
      if (bus.stop_go) begin
        if (wcnt == 0) begin bus.stop_finish = 1'b1; wcnt = -1; end
        else if (wcnt > 0) wcnt--;
      end

      bus.wr_valid = !rw && wr_idx < len && stall == 0;
      bus.wr_data = wdata[wr_idx % 16];
      if (fin) bus.cmd_valid = 1'b0;
    end

    if (abort) return;

    check("txn_finished", 32'(fin), 32'h1);
    check("event_count", 32'(obs_ev.size()), 32'(exp_ev.size()));
    for (int i = 0; i < exp_ev.size(); i++)
      if (i < obs_ev.size()) check($sformatf("event%0d", i), 32'(obs_ev[i]), 32'(exp_ev[i]));
    check("rd_count", 32'(obs_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size(); i++)
      if (i < obs_rd.size()) check($sformatf("rd_byte%0d", i), 32'(obs_rd[i]), 32'(exp_rd[i]));
    check("wr_ready_count", 32'(wr_idx), 32'(exp_nwr));
    check("nack_err_at_done", 32'(nack_obs), 32'(exp_nack));
    check("single_go", 32'(onehot_bad), 32'h0);
    check("stall_no_go", 32'(stall_bad), 32'h0);
    @(negedge clk);
    check("after_done_idle", 32'({bus.done, bus.busy, bus.cmd_ready}), 32'h1);
    check("nack_err_held", 32'(bus.nack_err), 32'(exp_nack));
  endtask

  initial begin
    clear_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_release");

    // write 0x50, two bytes, all ACK
    wdata[0] = 8'hA5; wdata[1] = 8'h3C;
    run_txn(1'b0, 7'h50, 2, -1, 0, 1'b0);

    // read 0x50, two bytes
    rdata[0] = 8'hC3; rdata[1] = 8'h5A;
    run_txn(1'b1, 7'h50, 2, -1, 0, 1'b0);

    // write with address NACK
    run_txn(1'b0, 7'h50, 2, 0, 0, 1'b0);

    // address-only probes, both directions
    run_txn(1'b1, 7'h50, 0, -1, 0, 1'b0);
    run_txn(1'b0, 7'h50, 0, -1, 0, 1'b0);

    // write data withheld for 20 cycles
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
    run_txn(1'b0, 7'h2B, 3, -1, 20, 1'b0);

    // NACK on the last write byte
    run_txn(1'b0, 7'h2B, 3, 3, 0, 1'b0);

    // reset while rb_go is high, then a fresh transaction
    rdata[0] = 8'h96; rdata[1] = 8'h69;
    run_txn(1'b1, 7'h3A, 2, -1, 0, 1'b1);
    clear_inputs();
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 7'h3A, 2, -1, 0, 1'b0);

    // randomized transactions
    for (int t = 0; t < 24; t++) begin
      bit         rw;
      logic [6:0] addr;
      int         len, nack_at;
      rw = 1'($urandom);
      addr = 7'($urandom);
      len = $urandom_range(0, 5);
      nack_at = ($urandom_range(0, 9) < 3) ? $urandom_range(0, len) : -1;
      for (int i = 0; i < 16; i++) begin
        wdata[i] = 8'($urandom);
        rdata[i] = 8'($urandom);
      end
      run_txn(rw, addr, len, nack_at, $urandom_range(0, 4), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
